nb_lch_loader: RTL

NB_LCH_LOADER -- requirements
Module: nb_lch_loader

---
 rtl/nb_lch_loader_pkg.sv | 14 +
 rtl/nb_lch_loader_bank_tracker.sv | 39 +++
 rtl/nb_lch_loader.sv | 99 +++++++++
 3 files changed

// File: rtl/nb_lch_loader_pkg.sv
// Shared decoder definitions: default word geometry and the loader FSM encoding.
package nb_lch_loader_pkg;

    localparam int LCH_DATA_W      = 48;
    localparam int LCH_ADDR_W      = 8;
    localparam int LCH_FRAME_WORDS = 200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b11
    } lch_state_t;

endpackage

// File: rtl/nb_lch_loader_bank_tracker.sv
// Ping-pong bank occupancy: set when a frame lands, cleared in order as the consumer releases.
module nb_bank_tracker
    import nb_lch_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       set_full,
    input  logic       set_bank,
    input  logic       bank_release,
    output logic [1:0] banks_full
);

    logic       rel_bank;
    logic       rel_ok;
    logic [1:0] full_next;

    // A release with nothing stored is spurious and must not move the pointer.
    always_comb begin
        rel_ok    = bank_release && (banks_full != 2'b00);
        full_next = banks_full;
        if (rel_ok) begin
            full_next[rel_bank] = 1'b0;
        end
        if (set_full) begin
            full_next[set_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            banks_full <= 2'b00;
            rel_bank   <= 1'b0;
        end else begin
            banks_full <= full_next;
            rel_bank   <= rel_bank ^ rel_ok;
        end
    end

endmodule

// File: rtl/nb_lch_loader.sv
// Channel-LLR loader: streams one frame into a free Lch bank and signals completion.
module nb_lch_loader
    import nb_lch_loader_pkg::*;
#(
    parameter int DATA_W      = LCH_DATA_W,
    parameter int ADDR_W      = LCH_ADDR_W,
    parameter int FRAME_WORDS = LCH_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              bank_release,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              data_ready,
    output logic [1:0]        banks_full
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_WORDS - 1);

    lch_state_t        state;
    lch_state_t        state_next;
    logic [ADDR_W-1:0] word_cnt;
    logic              wr_bank;
    logic              xfer;
    logic              done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (!banks_full[wr_bank]) state_next = ST_FILL;
            ST_FILL: if (xfer && (word_cnt == LAST_IDX)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_FILL);
        done     = (state == ST_DONE);
    end

    assign xfer = in_valid && in_ready;

    // Counter is re-cleared every pass through IDLE, so the post-frame overshoot never leaks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            wr_bank  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                word_cnt <= '0;
            end else if (xfer) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (done) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Write port is one cycle behind the accepted word; address/data hold between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            data_ready <= 1'b0;
        end else begin
            wr_en      <= xfer;
            data_ready <= done;
            if (xfer) begin
                wr_addr <= {wr_bank, word_cnt};
                wr_data <= in_data;
            end
        end
    end

    nb_bank_tracker u_tracker (
        .clk          (clk),
        .reset        (reset),
        .set_full     (done),
        .set_bank     (wr_bank),
        .bank_release (bank_release),
        .banks_full   (banks_full)
    );

endmodule
